// File: rtl/sum_of_numbers2_10.sv
// Binary to BCD converter using shift-and-add-3, consuming counterMod
// bits per cycle and publishing the digits and overflow flag on completion.
module sum_of_numbers2_10 #(
    parameter int binaryNumberWidth = 32,
    parameter int busWidth          = 4,
    parameter int counterMod        = 4,
    parameter int numberOfDigits    = 3
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [binaryNumberWidth-1:0]             binaryNumber,
    input  logic                                     load,
    output logic [numberOfDigits-1:0][busWidth-1:0]  BinaryDecimal,
    output logic                                     cOutShifter
);

    localparam int CYCLES = binaryNumberWidth / counterMod;
    localparam int CW     = $clog2(CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                                 state;
    logic [CW-1:0]                          cnt;
    logic [binaryNumberWidth-1:0]           bin_reg;
    logic [numberOfDigits-1:0][busWidth-1:0] digits;
    logic                                   ovf;

    logic [binaryNumberWidth-1:0]           nb;
    logic [numberOfDigits-1:0][busWidth-1:0] nd;
    logic                                   no;

    // counterMod double-dabble stages unrolled into one cycle
    always_comb begin
        nd = digits;
        nb = bin_reg;
        no = ovf;
        for (int s = 0; s < counterMod; s++) begin
            for (int i = 0; i < numberOfDigits; i++) begin
                if (nd[i] >= busWidth'(5))
                    nd[i] = nd[i] + busWidth'(3);
            end
            no = no | nd[numberOfDigits-1][busWidth-1];
            {nd, nb} = {nd, nb} << 1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            cnt           <= '0;
            bin_reg       <= '0;
            digits        <= '0;
            ovf           <= 1'b0;
            BinaryDecimal <= '0;
            cOutShifter   <= 1'b0;
        end else if (load) begin
            state   <= BUSY;
            cnt     <= '0;
            bin_reg <= binaryNumber;
            digits  <= '0;
            ovf     <= 1'b0;
        end else if (state == BUSY) begin
            bin_reg <= nb;
            digits  <= nd;
            ovf     <= no;
            if (cnt == LAST) begin
                state         <= IDLE;
                cnt           <= '0;
                BinaryDecimal <= nd;
                cOutShifter   <= no;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_sum_of_numbers2_10.sv
// Self-checking bench for sum_of_numbers2_10: vector table, corner
// sequences and randomized values against a decimal arithmetic model.
module tb_sum_of_numbers2_10;

    logic              clk = 1'b0;
    logic              rst;
    logic [31:0]       binaryNumber;
    logic              load;
    logic [2:0][3:0]   bd;
    logic              cout;

    int checks = 0;
    int errors = 0;

    logic [11:0] last_d;
    logic        last_c;

    sum_of_numbers2_10 dut (
        .clk           (clk),
        .rst           (rst),
        .binaryNumber  (binaryNumber),
        .load          (load),
        .BinaryDecimal (bd),
        .cOutShifter   (cout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] value;
        logic [11:0] exp_d;
        logic        exp_c;
    } vec_t;

    function automatic logic [11:0] model_bcd(input logic [31:0] v);
        longint unsigned r;
        r = longint'(v) % 1000;
        return {4'(r / 100), 4'((r / 10) % 10), 4'(r % 10)};
    endfunction

    task automatic chk(input string nm, input logic [11:0] ad,
                       input logic ac, input logic [11:0] ed,
                       input logic ec);
        checks++;
        if (ad !== ed || ac !== ec) begin
            errors++;
            $display("FAIL %s: got digits=%h ovf=%b, expected digits=%h ovf=%b",
                     nm, ad, ac, ed, ec);
        end
    endtask

    task automatic finish_conv(input string nm, input logic [11:0] ed,
                               input logic ec);
        for (int k = 1; k < 8; k++) begin
            @(negedge clk);
            chk({nm, "_hold"}, bd, cout, last_d, last_c);
        end
        @(negedge clk);
        chk(nm, bd, cout, ed, ec);
        last_d = ed;
        last_c = ec;
    endtask

    task automatic run_conv(input string nm, input logic [31:0] v,
                            input logic [11:0] ed, input logic ec);
        @(negedge clk);
        binaryNumber = v;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        finish_conv(nm, ed, ec);
    endtask

    vec_t vecs[8];

    initial begin
        logic [31:0] rv;

        vecs[0] = '{32'h0000000B, 12'h011, 1'b0};
        vecs[1] = '{32'd999,      12'h999, 1'b0};
        vecs[2] = '{32'd1000,     12'h000, 1'b1};
        vecs[3] = '{32'hFFFFFFFF, 12'h295, 1'b1};
        vecs[4] = '{32'd0,        12'h000, 1'b0};
        vecs[5] = '{32'd5,        12'h005, 1'b0};
        vecs[6] = '{32'd100,      12'h100, 1'b0};
        vecs[7] = '{32'd1234567,  12'h567, 1'b1};

        rst = 1'b0;
        load = 1'b0;
        binaryNumber = '0;
        last_d = '0;
        last_c = 1'b0;
        #3;
        chk("reset_init", bd, cout, 12'h000, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        foreach (vecs[i])
            run_conv($sformatf("vec%0d", i), vecs[i].value,
                     vecs[i].exp_d, vecs[i].exp_c);

        // abort: 123 restarted by 45 four cycles later
        @(negedge clk);
        binaryNumber = 32'd123;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            chk("abort_hold_a", bd, cout, last_d, last_c);
        end
        binaryNumber = 32'd45;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        finish_conv("abort_45", 12'h045, 1'b0);

        // load held for three edges restarts each time
        @(negedge clk);
        binaryNumber = 32'd700;
        load = 1'b1;
        @(negedge clk);
        binaryNumber = 32'd801;
        @(negedge clk);
        binaryNumber = 32'd77;
        @(negedge clk);
        load = 1'b0;
        finish_conv("held_load", 12'h077, 1'b0);

        for (int i = 0; i < 24; i++) begin
            rv = (i % 2 == 0) ? $urandom : 32'($urandom_range(0, 1500));
            run_conv($sformatf("rand%0d_%0d", i, rv), rv,
                     model_bcd(rv), rv >= 32'd1000);
        end

        // asynchronous reset mid-cycle with a non-zero result shown
        run_conv("pre_reset", 32'd642, 12'h642, 1'b0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("reset_async", bd, cout, 12'h000, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        last_d = '0;
        last_c = 1'b0;

        // reset during a 500 conversion: nothing is published
        @(negedge clk);
        binaryNumber = 32'd500;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("busy_reset", bd, cout, 12'h000, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk("busy_reset_quiet", bd, cout, 12'h000, 1'b0);
        end

        run_conv("after_reset", 32'd314, 12'h314, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
